uart_rx_deserializer: RTL and testbench
=======================================

Name: uart_rx_deserializer

Overview:
- UART receive path: oversamples the serial line `rx_in`, detects the start bit, and majority-votes each bit.
- Shifts in the data bits LSB-first, then checks the optional parity bit and the stop bit.
- Presents the received byte on `p_data` with a single-cycle `data_valid` strobe.
- Counterpart of the TX serializer/FSM in the UART block; sits behind the RX clock-domain crossing, feeding the system controller.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_W, 6, width of the `prescale` input and of the oversampling edge counter.

Ports:
- clk  input  1  RX oversampling clock.
- rst  input  1  asynchronous, active-low reset.
- rx_in  input  1  serial line; idle high.
- prescale  input  PRESCALE_W  clocks per bit; legal values 8, 16, 32; other values give undefined behaviour.
- par_en  input  1  1 = frame carries a parity bit.
- par_typ  input  1  0 = even parity, 1 = odd parity.
- p_data  output  DATA_WIDTH  last good byte received.
- data_valid  output  1  one-cycle strobe: `p_data` updated.
- par_err  output  1  parity mismatch on the last frame.
- stp_err  output  1  stop bit sampled 0 on the last frame.

Behaviour:
- Reset values: `p_data` = 0, `data_valid` = 0, `par_err` = 0, `stp_err` = 0; FSM in IDLE; all counters 0. Reset mid-frame aborts the frame with no outputs asserted.
- Configuration latch: `prescale`, `par_en` and `par_typ` are latched on the IDLE->START transition. Changes during a frame have no effect until the next frame.
- Edge counter `edge_cnt`:
  - In all states except IDLE it increments every clk, range 0..P-1, where P is the latched prescale.
  - At P-1 it wraps to 0 and `bit_cnt` increments.
- Sampling:
  - `rx_in` is sampled at `edge_cnt` = P/2-1, P/2 and P/2+1.
  - Bit value = majority of the 3 samples.
  - The bit is evaluated at `edge_cnt` = P/2+2 (the "check point").
- FSM states and transitions:
  - IDLE: on `rx_in` = 0, go to START with `edge_cnt` = 0 and `bit_cnt` = 0; clear `par_err` and `stp_err`.
  - START: at the check point, if the bit = 1 (glitch), return to IDLE with no error flagged. Otherwise stay in START until `edge_cnt` = P-1, then go to DATA.
  - DATA: at each check point, shift the bit into `shift_reg` LSB-first (bit 0 received first). After DATA_WIDTH bits (at the wrap following the last bit), go to PARITY if `par_en` = 1, else to STOP.
  - PARITY: at the check point compute the expected parity = XOR(`shift_reg`) XOR `par_typ`. If the received bit != expected, set `par_err` = 1. At the wrap, go to STOP.
  - STOP: at the check point:
    - if the bit = 0, set `stp_err` = 1;
    - if the bit = 1 and `par_err` = 0, load `p_data` <= `shift_reg` and assert `data_valid` for exactly the next clk;
    - go to IDLE immediately (mid-stop-bit).
- Frame errors: on an errored frame, `p_data` holds its previous value and `data_valid` stays 0. The error flags hold until the next start detection.
- Back-to-back frames: a start edge arriving immediately after the stop bit must be detected. Because FSM returns to IDLE mid-stop, IDLE sees `rx_in` = 1 before the next falling edge.
- Line held low (break): behaves as a frame of all zeros with `stp_err` = 1. FSM then re-enters START as soon as IDLE sees `rx_in` = 0 again.
- Latency: `data_valid` rises P/2+3 clk after the start of the stop bit.

Optional Feature:
- Macro: RX_SYNC_EN.
- Defined: `rx_in` passes through a 2-flop synchronizer, both flops reset to 1; all FSM timing shifts by 2 clk.
- Undefined: `rx_in` is used directly; the upstream block guarantees synchronicity.

Test Plan:
- `prescale` = 8, `par_en` = 0, send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> `p_data` = 0xA5; `data_valid` high for exactly 1 clk; `par_err` = `stp_err` = 0.
- `prescale` = 16, `par_en` = 1, `par_typ` = 0, send 0x3C with parity bit 0 -> `p_data` = 0x3C, `data_valid` pulse. Same frame with parity bit 1 -> `par_err` = 1, no `data_valid`, `p_data` still 0x3C from the previous frame.
- `prescale` = 32, send 0x81 with stop bit 0 -> `stp_err` = 1, no `data_valid`. Next good frame 0x55 -> `stp_err` clears at its start edge, then `data_valid` with `p_data` = 0x55.
- `prescale` = 8, drive `rx_in` low for 2 clk then high -> FSM returns to IDLE, no flags; a following valid frame 0x0F is received correctly.
- Back-to-back frames 0x12 then 0x34 with no idle gap, `prescale` = 8 -> two `data_valid` pulses exactly 10×8 clk apart, with `p_data` = 0x12 then 0x34.
- Assert `rst` during DATA bit 4 of 0xFF, release, then send 0x6A -> no pulse for the aborted frame; `p_data` = 0x6A with one `data_valid`.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: oversampled start detection, 3-sample majority vote,
// LSB-first shift, optional parity and stop check. Define RX_SYNC_EN to add a 2-flop rx_in synchronizer.
module uart_rx_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                  state_q, state_d;
  logic [PRESCALE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
  logic                    data_valid_q, data_valid_d;
  logic                    par_err_q, par_err_d;
  logic                    stp_err_q, stp_err_d;
  logic [PRESCALE_W-1:0]   prescale_q, prescale_d;
  logic                    par_en_q, par_en_d;
  logic                    par_typ_q, par_typ_d;
  logic [2:0]              samp_q, samp_d;
  logic                    rx_s;

`ifdef RX_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;
`else
  assign rx_s = rx_in;
`endif

  logic [PRESCALE_W-1:0] half;
  logic                  at_wrap;
  logic                  at_check;
  logic                  bit_val;

  assign half     = prescale_q >> 1;
  assign at_wrap  = (edge_cnt_q == prescale_q - PRESCALE_W'(1));
  assign at_check = (edge_cnt_q == half + PRESCALE_W'(2));
  assign bit_val  = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

  always_comb begin
    state_d      = state_q;
    edge_cnt_d   = edge_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = par_err_q;
    stp_err_d    = stp_err_q;
    prescale_d   = prescale_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    samp_d       = samp_q;

    if (state_q != IDLE) begin
      if (at_wrap) begin
        edge_cnt_d = '0;
        bit_cnt_d  = bit_cnt_q + BCW'(1);
      end else begin
        edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
      end
      if (edge_cnt_q == half - PRESCALE_W'(1)) samp_d[0] = rx_s;
      if (edge_cnt_q == half)                  samp_d[1] = rx_s;
      if (edge_cnt_q == half + PRESCALE_W'(1)) samp_d[2] = rx_s;
    end

    case (state_q)
      IDLE: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!rx_s) begin
          state_d    = START;
          par_err_d  = 1'b0;
          stp_err_d  = 1'b0;
          prescale_d = prescale;
          par_en_d   = par_en;
          par_typ_d  = par_typ;
        end
      end
      START: begin
        if (at_check && bit_val) begin
          state_d    = IDLE;
          edge_cnt_d = '0;
          bit_cnt_d  = '0;
        end else if (at_wrap) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (at_check) shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
        if (at_wrap && bit_cnt_q == BCW'(DATA_WIDTH)) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (at_check && (bit_val != (^shift_q ^ par_typ_q))) par_err_d = 1'b1;
        if (at_wrap) state_d = STOP;
      end
      STOP: begin
        // Leave mid-stop-bit so a start edge right after the stop bit is seen.
        if (at_check) begin
          if (!bit_val) begin
            stp_err_d = 1'b1;
          end else if (!par_err_q) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end
          state_d    = IDLE;
          edge_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      prescale_q   <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      samp_q       <= '0;
    end else begin
      state_q      <= state_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
      prescale_q   <= prescale_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      samp_q       <= samp_d;
    end
  end

  assign p_data     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer: good frames push their byte,
// a negedge monitor pops and compares on every data_valid pulse.
module tb_uart_rx_deserializer;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int assertCount = 0;
  int failCount   = 0;
  int cycleCnt    = 0;
  int stopCycle   = 0;
  int curP        = 8;
  int dvCount     = 0;
  int lastDvCycle = 0;
  int prevDvCycle = 0;
  logic dvPrev    = 1'b0;
  logic [7:0] expQ[$];

  uart_rx_deserializer #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .prescale   (prescale),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cycleCnt);
    end
  endtask

  // Every pulse must be expected, carry the right byte, be one clock wide and land P/2+3 after the stop bit starts.
  always @(negedge clk) begin
    if (rst && data_valid) begin
      dvCount++;
      prevDvCycle = lastDvCycle;
      lastDvCycle = cycleCnt;
      if (expQ.size() == 0) begin
        checkOutput("dv_unexpected", 32'd1, 32'd0);
      end else begin
        checkOutput("p_data", {24'd0, p_data}, {24'd0, expQ.pop_front()});
      end
      checkOutput("dv_width", {31'd0, dvPrev}, 32'd0);
      checkOutput("dv_latency", cycleCnt - stopCycle, curP / 2 + 3);
    end
    dvPrev = data_valid;
  end

  task automatic idleCycles(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input int p, input logic parEn,
                               input logic parTyp, input logic badPar, input logic stopBit);
    logic parBit;
    logic good;
    parBit   = (^data) ^ parTyp ^ badPar;
    good     = stopBit && !(parEn && badPar);
    prescale = 6'(p);
    par_en   = parEn;
    par_typ  = parTyp;
    curP     = p;
    if (good) expQ.push_back(data);
    rx_in = 1'b0;
    @(negedge clk);
    checkOutput("flags_clear_at_start", {30'd0, par_err, stp_err}, 32'd0);
    repeat (p - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = data[i];
      repeat (p) @(negedge clk);
    end
    if (parEn) begin
      rx_in = parBit;
      repeat (p) @(negedge clk);
    end
    rx_in     = stopBit;
    stopCycle = cycleCnt + 1;
    repeat (p / 2 + 4) @(negedge clk);
    checkOutput("stop_stp_err", {31'd0, stp_err}, {31'd0, !stopBit});
    checkOutput("stop_par_err", {31'd0, par_err}, {31'd0, parEn && badPar});
    checkOutput("stop_dv", {31'd0, data_valid}, {31'd0, good});
    repeat (p - p / 2 - 4) @(negedge clk);
    rx_in = 1'b1;
  endtask

  initial begin
    rst      = 1'b0;
    rx_in    = 1'b1;
    prescale = 6'd8;
    par_en   = 1'b0;
    par_typ  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_p_data", {24'd0, p_data}, 32'd0);
    checkOutput("reset_dv", {31'd0, data_valid}, 32'd0);
    checkOutput("reset_par_err", {31'd0, par_err}, 32'd0);
    checkOutput("reset_stp_err", {31'd0, stp_err}, 32'd0);
    rst = 1'b1;
    idleCycles(4);

    $display("[TB] prescale 8, no parity, 0xA5");
    applyStimulus(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    idleCycles(16);
    checkOutput("a5_p_data", {24'd0, p_data}, 32'hA5);

    $display("[TB] prescale 16, even parity, 0x3C good then bad parity");
    applyStimulus(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1);
    idleCycles(32);
    applyStimulus(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1);
    idleCycles(32);
    checkOutput("badpar_par_err_hold", {31'd0, par_err}, 32'd1);
    checkOutput("badpar_p_data_hold", {24'd0, p_data}, 32'h3C);

    $display("[TB] prescale 32, stop error on 0x81, then 0x55");
    applyStimulus(8'h81, 32, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycles(64);
    checkOutput("stperr_p_data_hold", {24'd0, p_data}, 32'h3C);
    applyStimulus(8'h55, 32, 1'b0, 1'b0, 1'b0, 1'b1);
    idleCycles(64);
    checkOutput("after_stperr_flags", {30'd0, par_err, stp_err}, 32'd0);

    $display("[TB] prescale 8, 2-clock glitch then 0x0F");
    prescale = 6'd8;
    rx_in    = 1'b0;
    repeat (2) @(negedge clk);
    idleCycles(20);
    checkOutput("glitch_flags", {30'd0, par_err, stp_err}, 32'd0);
    checkOutput("glitch_p_data", {24'd0, p_data}, 32'h55);
    applyStimulus(8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    idleCycles(16);

    $display("[TB] back-to-back 0x12, 0x34");
    applyStimulus(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h34, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    idleCycles(16);
    checkOutput("b2b_spacing", lastDvCycle - prevDvCycle, 32'd80);
    checkOutput("b2b_p_data", {24'd0, p_data}, 32'h34);

    $display("[TB] reset during data bit 4 of 0xFF, then 0x6A");
    prescale = 6'd8;
    par_en   = 1'b0;
    rx_in    = 1'b0;
    repeat (8) @(negedge clk);
    rx_in = 1'b1;
    repeat (4 * 8 + 4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_p_data", {24'd0, p_data}, 32'd0);
    checkOutput("midreset_dv", {31'd0, data_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idleCycles(16);
    applyStimulus(8'h6A, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    idleCycles(16);
    checkOutput("final_p_data", {24'd0, p_data}, 32'h6A);

    checkOutput("total_dv_pulses", dvCount, 32'd7);
    checkOutput("scoreboard_empty", expQ.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
